sipo_rx_ctrl: RTL and testbench
===============================

Name: sipo_rx_ctrl

Overview:
- Serial-in, parallel-out receiver for the 4-bit shift-register transfer path.
- Accepts a serial stream LSB-first, one bit per cycle when si_en is high.
- After WIDTH bits, presents the assembled word on a parallel output register with a valid/ready handshake.
- Adds overrun detection; optional parity checking.

Parameters:
- WIDTH, 4, data bits per word (≥2).

Ports:
- clk  input  1  clock, rising edge.
- rstb  input  1  reset, asynchronous, active-low.
- si  input  1  serial data in, LSB first.
- si_en  input  1  qualifies si; one bit consumed per cycle when high.
- clr  input  1  synchronous frame abort; clears partial word and overrun.
- dout  output  WIDTH  received word.
- dout_valid  output  1  dout holds an unconsumed word.
- dout_ready  input  1  consumer accepts dout.
- bit_cnt  output  $clog2(WIDTH+1)  data bits received in the current frame.
- busy  output  1  frame in progress (state != IDLE).
- overrun  output  1  sticky; a word completed while the output register was full.
- par_err  output  1  parity error for the word in dout; tied 0 without the macro.

Behaviour:
- Reset, async on rstb low:
  - State IDLE; shift register 0; bit_cnt 0.
  - dout 0; dout_valid 0; overrun 0; par_err 0; busy 0.
- Shift: on each si_en cycle, sr <= {si, sr[WIDTH-1:1]}. The first received bit ends in dout[0].
- FSM:
  - IDLE: si_en → SHIFT, bit_cnt=1.
  - SHIFT: si_en increments bit_cnt. On the si_en cycle with bit_cnt==WIDTH-1, the word {si, sr[WIDTH-1:1]} completes; go to IDLE (PARITY with macro); bit_cnt=0.
  - si_en low in any state: hold, no timeout.
- Completion latency: dout and dout_valid update on the clock edge that samples the last bit, so dout_valid is visible the following cycle.
- Handshake:
  - dout_valid && dout_ready at an edge clears dout_valid.
  - dout is stable while dout_valid=1.
- Simultaneous completion and pop: the new word loads, dout_valid stays 1, no overrun.
- Completion while dout_valid=1 and dout_ready=0:
  - The new word is dropped and dout is unchanged.
  - overrun is set and stays set until clr or reset.
- clr:
  - Priority over si_en.
  - Next edge: state IDLE, bit_cnt 0, sr 0, overrun 0.
  - dout, dout_valid and par_err are unaffected.
- A back-to-back frame starting the cycle after completion is legal; there is no dead cycle.
- Reset mid-frame discards the partial word. No output pulse follows reset.

Optional Feature:
- Macro SIPO_RX_PARITY_EN.
- Defined:
  - After WIDTH data bits, FSM enters PARITY and consumes one more si_en bit (even parity).
  - The word is delivered on the edge that samples the parity bit.
  - par_err = ^data ^ parity_bit, loaded with dout and held with it.
  - Overrun and handshake rules apply at delivery time.
- Undefined: no PARITY state; par_err constant 0.

Decomposition:
- Shared package/include sipo_rx_pkg holds:
  - State encodings: IDLE=2'd0, SHIFT=2'd1, PARITY=2'd2.
  - Default WIDTH.
- One sub-module is natural: rx_out_reg. It is a WIDTH+1-bit holding register with valid/ready, load, and overrun-detect outputs, and is reusable by other receivers.

Test Plan (WIDTH=4):
- Basic frame: si_en=1 for 4 cycles, si=1,0,1,1 → the cycle after the 4th bit, dout=4'hD, dout_valid=1, bit_cnt=0, busy=0; pop with dout_ready → dout_valid=0 next cycle.
- Gapped bits: same bits, si_en low 3 cycles between bits → bit_cnt holds during gaps; dout=4'hD; busy=1 throughout the frame.
- Overrun: frame 4'hD, hold dout_ready=0, send frame 4'h3 → dout stays 4'hD, overrun=1; clr → overrun=0, dout_valid still 1.
- Simultaneous pop: frame 4'hA, then frame 4'h5 with dout_ready=1 on the completing cycle → dout=4'h5, dout_valid=1, overrun=0.
- Reset mid-frame: 2 bits in, rstb low 1 cycle → all outputs 0; next full frame 4'h6 is received correctly.
- Parity (macro defined): data 4'hD plus parity bit 1 → par_err=0; same data with parity bit 0 → par_err=1; dout_valid only after the 5th bit.

Source files
------------

// File: rtl/sipo_rx_pkg.sv
// Shared constants for the serial-in/parallel-out receiver: FSM state
// encodings and the default word width.
package sipo_rx_pkg;

  localparam int DEFAULT_WIDTH = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;

endpackage

// File: rtl/rx_out_reg.sv
// Output holding register with valid/ready handshake. A load while full and
// not being popped is dropped and flagged on overrun_det for that cycle.
module rx_out_reg #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rstb,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         ready,
  output logic [W-1:0] data,
  output logic         valid,
  output logic         overrun_det
);

  logic [W-1:0] r_data;
  logic         r_valid;
  logic         w_accept;

  // A load is taken when the register is empty or is being popped this cycle.
  assign w_accept    = load && (!r_valid || ready);
  assign overrun_det = load && r_valid && !ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_data  <= load_data;
      r_valid <= 1'b1;
    end else if (r_valid && ready) begin
      r_valid <= 1'b0;
    end
  end

  assign data  = r_data;
  assign valid = r_valid;

endmodule

// File: rtl/sipo_rx_ctrl.sv
// Serial-in, parallel-out receiver, LSB first, with sticky overrun.
// Define SIPO_RX_PARITY_EN to consume a trailing even-parity bit per word.
module sipo_rx_ctrl
  import sipo_rx_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                         clk,
  input  logic                         rstb,
  input  logic                         si,
  input  logic                         si_en,
  input  logic                         clr,
  output logic [WIDTH-1:0]             dout,
  output logic                         dout_valid,
  input  logic                         dout_ready,
  output logic [$clog2(WIDTH+1)-1:0]   bit_cnt,
  output logic                         busy,
  output logic                         overrun,
  output logic                         par_err
);

  localparam int            CW   = $clog2(WIDTH+1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH-1);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_sr;
  logic [CW-1:0]    r_bit_cnt;
  logic             r_overrun;

  logic [WIDTH-1:0] w_shift;
  logic             w_load;
  logic [WIDTH:0]   w_load_data;
  logic [WIDTH:0]   w_out;
  logic             w_ovr_det;

  assign w_shift = {si, r_sr[WIDTH-1:1]};

`ifdef SIPO_RX_PARITY_EN
  // Data is already complete in r_sr; the parity bit is the delivery strobe.
  assign w_load      = si_en && !clr && (r_state == ST_PARITY);
  assign w_load_data = {(^r_sr) ^ si, r_sr};
`else
  assign w_load      = si_en && !clr && (r_state == ST_SHIFT) && (r_bit_cnt == LAST);
  assign w_load_data = {1'b0, w_shift};
`endif

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state   <= ST_IDLE;
      r_sr      <= '0;
      r_bit_cnt <= '0;
      r_overrun <= 1'b0;
    end else if (clr) begin
      r_state   <= ST_IDLE;
      r_sr      <= '0;
      r_bit_cnt <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_ovr_det) r_overrun <= 1'b1;
      if (si_en) begin
        case (r_state)
          ST_IDLE: begin
            r_sr      <= w_shift;
            r_bit_cnt <= CW'(1);
            r_state   <= ST_SHIFT;
          end
          ST_SHIFT: begin
            r_sr <= w_shift;
            if (r_bit_cnt == LAST) begin
              r_bit_cnt <= '0;
`ifdef SIPO_RX_PARITY_EN
              r_state   <= ST_PARITY;
`else
              r_state   <= ST_IDLE;
`endif
            end else begin
              r_bit_cnt <= r_bit_cnt + CW'(1);
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  rx_out_reg #(.W(WIDTH+1)) u_out_reg (
    .clk         (clk),
    .rstb        (rstb),
    .load        (w_load),
    .load_data   (w_load_data),
    .ready       (dout_ready),
    .data        (w_out),
    .valid       (dout_valid),
    .overrun_det (w_ovr_det)
  );

  assign dout    = w_out[WIDTH-1:0];
  assign par_err = w_out[WIDTH];
  assign bit_cnt = r_bit_cnt;
  assign busy    = (r_state != ST_IDLE);
  assign overrun = r_overrun;

endmodule

// File: tb/tb_sipo_rx_ctrl.sv
// Self-checking bench for sipo_rx_ctrl (WIDTH=4): directed scenarios plus a
// randomized run against a bit-accumulating reference model.
module tb_sipo_rx_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rstb = 1'b0;
  logic         si = 1'b0;
  logic         si_en = 1'b0;
  logic         clr = 1'b0;
  logic         dout_ready = 1'b0;
  logic [W-1:0] dout;
  logic         dout_valid;
  logic [2:0]   bit_cnt;
  logic         busy;
  logic         overrun;
  logic         par_err;

  int n_checks = 0;
  int n_errors = 0;

  sipo_rx_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .rstb       (rstb),
    .si         (si),
    .si_en      (si_en),
    .clr        (clr),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .bit_cnt    (bit_cnt),
    .busy       (busy),
    .overrun    (overrun),
    .par_err    (par_err)
  );

  always #5 clk = ~clk;

  // One clock cycle with the given inputs; returns 1 time unit after the edge.
  task automatic drive(input logic s, input logic en, input logic rdy, input logic c);
    si = s; si_en = en; dout_ready = rdy; clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    si = 0; si_en = 0; dout_ready = 0; clr = 0;
    rstb = 1'b0;
    @(posedge clk);
    #1;
    rstb = 1'b1;
  endtask

  // Sends one word LSB first (plus its even-parity bit in the parity build);
  // rdy_last is applied on the completing cycle only.
  task automatic send_frame(input logic [W-1:0] w, input logic rdy_last);
    for (int i = 0; i < W-1; i++) drive(w[i], 1'b1, 1'b0, 1'b0);
`ifdef SIPO_RX_PARITY_EN
    drive(w[W-1], 1'b1, 1'b0, 1'b0);
    drive(^w, 1'b1, rdy_last, 1'b0);
`else
    drive(w[W-1], 1'b1, rdy_last, 1'b0);
`endif
  endtask

  task automatic test_reset();
    rstb = 1'b0;
    #3;
    n_checks++;
    if ({dout, dout_valid, bit_cnt, busy, overrun, par_err} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs got dout=%h v=%b cnt=%0d busy=%b ovr=%b perr=%b required all 0",
               dout, dout_valid, bit_cnt, busy, overrun, par_err);
    end
    do_reset();
  endtask

  task automatic test_basic();
    do_reset();
    send_frame(4'hD, 1'b0);
    n_checks++;
    if (dout !== 4'hD || dout_valid !== 1'b1 || bit_cnt !== 3'd0 || busy !== 1'b0 || par_err !== 1'b0) begin
      n_errors++;
      $display("FAIL basic_frame got dout=%h v=%b cnt=%0d busy=%b perr=%b required D 1 0 0 0",
               dout, dout_valid, bit_cnt, busy, par_err);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (dout_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL basic_pop got valid=%b required 0", dout_valid);
    end
  endtask

  task automatic test_gapped();
    logic [W-1:0] w;
    w = 4'hD;
    do_reset();
    for (int i = 0; i < W-1; i++) begin
      drive(w[i], 1'b1, 1'b0, 1'b0);
      for (int g = 0; g < 3; g++) begin
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (bit_cnt !== 3'(i+1) || busy !== 1'b1 || dout_valid !== 1'b0) begin
          n_errors++;
          $display("FAIL gapped_hold bit=%0d got cnt=%0d busy=%b v=%b required %0d 1 0",
                   i, bit_cnt, busy, dout_valid, i+1);
        end
      end
    end
`ifdef SIPO_RX_PARITY_EN
    drive(w[W-1], 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(^w, 1'b1, 1'b0, 1'b0);
`else
    drive(w[W-1], 1'b1, 1'b0, 1'b0);
`endif
    n_checks++;
    if (dout !== 4'hD || dout_valid !== 1'b1 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL gapped_word got dout=%h v=%b busy=%b required D 1 0", dout, dout_valid, busy);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    send_frame(4'hD, 1'b0);
    send_frame(4'h3, 1'b0);
    n_checks++;
    if (dout !== 4'hD || dout_valid !== 1'b1 || overrun !== 1'b1) begin
      n_errors++;
      $display("FAIL overrun_set got dout=%h v=%b ovr=%b required D 1 1", dout, dout_valid, overrun);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (overrun !== 1'b1) begin
      n_errors++;
      $display("FAIL overrun_sticky got %b required 1", overrun);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    n_checks++;
    if (overrun !== 1'b0 || dout_valid !== 1'b1 || dout !== 4'hD || bit_cnt !== 3'd0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL overrun_clr got ovr=%b v=%b dout=%h cnt=%0d busy=%b required 0 1 D 0 0",
               overrun, dout_valid, dout, bit_cnt, busy);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    send_frame(4'hA, 1'b0);
    send_frame(4'h5, 1'b1);
    n_checks++;
    if (dout !== 4'h5 || dout_valid !== 1'b1 || overrun !== 1'b0) begin
      n_errors++;
      $display("FAIL simul_pop got dout=%h v=%b ovr=%b required 5 1 0", dout, dout_valid, overrun);
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    si_en = 1'b0;
    rstb = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if ({dout, dout_valid, bit_cnt, busy, overrun, par_err} !== '0) begin
      n_errors++;
      $display("FAIL midreset_outputs got dout=%h v=%b cnt=%0d busy=%b ovr=%b required all 0",
               dout, dout_valid, bit_cnt, busy, overrun);
    end
    rstb = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (dout_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL midreset_no_pulse got valid=%b required 0", dout_valid);
    end
    send_frame(4'h6, 1'b0);
    n_checks++;
    if (dout !== 4'h6 || dout_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL midreset_next got dout=%h v=%b required 6 1", dout, dout_valid);
    end
  endtask

`ifdef SIPO_RX_PARITY_EN
  task automatic test_parity();
    logic [W-1:0] w;
    w = 4'hD;
    do_reset();
    for (int i = 0; i < W; i++) drive(w[i], 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (dout_valid !== 1'b0 || busy !== 1'b1 || bit_cnt !== 3'd0) begin
      n_errors++;
      $display("FAIL parity_wait got v=%b busy=%b cnt=%0d required 0 1 0", dout_valid, busy, bit_cnt);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (dout !== 4'hD || dout_valid !== 1'b1 || par_err !== 1'b0) begin
      n_errors++;
      $display("FAIL parity_good got dout=%h v=%b perr=%b required D 1 0", dout, dout_valid, par_err);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < W; i++) drive(w[i], 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (dout !== 4'hD || dout_valid !== 1'b1 || par_err !== 1'b1) begin
      n_errors++;
      $display("FAIL parity_bad got dout=%h v=%b perr=%b required D 1 1", dout, dout_valid, par_err);
    end
  endtask
`endif

  // Reference model: accumulates bits arithmetically into a word and applies
  // the handshake/overrun/clr rules once per cycle.
  task automatic test_random();
    int           m_cnt;
    int           m_word;
    bit           m_in_par;
    logic [W-1:0] m_dout;
    bit           m_valid, m_ovr, m_perr;
    bit           s, en, rdy, c, deliver, new_perr;
    int           got_word;
    do_reset();
    m_cnt = 0; m_word = 0; m_in_par = 0;
    m_dout = '0; m_valid = 0; m_ovr = 0; m_perr = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      s   = 1'($urandom_range(0, 1));
      en  = ($urandom_range(0, 9) < 7);
      rdy = ($urandom_range(0, 9) < 4);
      c   = ($urandom_range(0, 49) == 0);
      drive(s, en, rdy, c);

      deliver  = 0;
      new_perr = 0;
      got_word = 0;
      if (c) begin
        m_cnt = 0; m_word = 0; m_in_par = 0; m_ovr = 0;
      end else if (en) begin
        if (m_in_par) begin
          deliver  = 1;
          got_word = m_word;
          new_perr = ($countones(m_word) + int'(s)) % 2 == 1;
          m_in_par = 0; m_word = 0;
        end else begin
          m_word = m_word + (int'(s) << m_cnt);
          m_cnt++;
          if (m_cnt == W) begin
            m_cnt = 0;
`ifdef SIPO_RX_PARITY_EN
            m_in_par = 1;
`else
            deliver  = 1;
            got_word = m_word;
            m_word   = 0;
`endif
          end
        end
      end
      if (deliver && m_valid && !rdy) begin
        m_ovr = 1;
      end else if (deliver) begin
        m_dout  = W'(got_word);
        m_valid = 1;
        m_perr  = new_perr;
      end else if (m_valid && rdy) begin
        m_valid = 0;
      end

      n_checks++;
      if (dout !== m_dout || dout_valid !== m_valid || bit_cnt !== 3'(m_cnt) ||
          busy !== (m_cnt != 0 || m_in_par) || overrun !== m_ovr || par_err !== m_perr) begin
        n_errors++;
        $display("FAIL random cyc=%0d got dout=%h v=%b cnt=%0d busy=%b ovr=%b perr=%b required %h %b %0d %b %b %b",
                 cyc, dout, dout_valid, bit_cnt, busy, overrun, par_err,
                 m_dout, m_valid, m_cnt, (m_cnt != 0 || m_in_par), m_ovr, m_perr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gapped();
    test_overrun();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef SIPO_RX_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
